multi_ch_data_sync: RTL

//  Multi-channel bus synchroniser for the destination clock domain, with one output

---
 rtl/multi_ch_data_sync.sv | 110 +++++++++++
 1 files changed

// File: rtl/multi_ch_data_sync.sv
// Multi-channel enable/bus synchroniser into the CLK domain with one round-robin output stream.
// Ports: CLK/RST (sync, active-high); unsync_bus/bus_enable async per-channel inputs;
//   sync_bus/enable_pulse per-channel capture results; out_data/out_ch/out_valid/out_ready
//   arbitrated stream; overflow sticky per-channel overwrite flags, cleared by ovf_clr.
module multi_ch_data_sync #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter int NUM_STAGES = 2,
  localparam int CH_ID_W   = $clog2(NUM_CH)
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_CH*DATA_WIDTH-1:0] unsync_bus,
  input  logic [NUM_CH-1:0]            bus_enable,
  output logic [NUM_CH*DATA_WIDTH-1:0] sync_bus,
  output logic [NUM_CH-1:0]            enable_pulse,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CH_ID_W-1:0]           out_ch,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_CH-1:0]            overflow,
  input  logic                         ovf_clr
);

  logic [NUM_STAGES-1:0] en_sync [NUM_CH];
  logic [NUM_CH-1:0]     en_prev;
  logic [NUM_CH-1:0]     rise;
  logic [NUM_CH-1:0]     pending;
  logic [NUM_CH-1:0]     pending_nxt;
  logic [NUM_CH-1:0]     overflow_nxt;
  logic [NUM_CH-1:0]     grant_clr;
  logic [CH_ID_W-1:0]    last_grant;
  logic [CH_ID_W-1:0]    grant;
  logic                  found;
  logic                  load;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      rise[i] = en_sync[i][NUM_STAGES-1] & ~en_prev[i];
    end
  end

  // Round-robin: first search channels above last_grant, then wrap to the bottom.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && pending[i] && (i > int'(last_grant))) begin
        grant = CH_ID_W'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && pending[i] && (i <= int'(last_grant))) begin
        grant = CH_ID_W'(i);
        found = 1'b1;
      end
    end
  end

  assign load = (~out_valid | out_ready) & (|pending);

  // A capture on the channel being loaded refills pending with the new word
  // instead of counting as an overwrite; the load itself takes the old word.
  always_comb begin
    grant_clr = '0;
    if (load) begin
      grant_clr[grant] = 1'b1;
    end
    pending_nxt  = (pending & ~grant_clr) | rise;
    overflow_nxt = (ovf_clr ? '0 : overflow) | (rise & pending & ~grant_clr);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_CH; i++) begin
        en_sync[i] <= '0;
      end
      en_prev      <= '0;
      enable_pulse <= '0;
      sync_bus     <= '0;
      pending      <= '0;
      overflow     <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_ch       <= '0;
      last_grant   <= CH_ID_W'(NUM_CH - 1);
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        en_sync[i] <= {en_sync[i][NUM_STAGES-2:0], bus_enable[i]};
        en_prev[i] <= en_sync[i][NUM_STAGES-1];
        if (rise[i]) begin
          sync_bus[i*DATA_WIDTH +: DATA_WIDTH] <= unsync_bus[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      enable_pulse <= rise;
      pending      <= pending_nxt;
      overflow     <= overflow_nxt;
      if (load) begin
        out_valid  <= 1'b1;
        out_data   <= sync_bus[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
        out_ch     <= grant;
        last_grant <= grant;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
